// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, word-addressed instruction memory and the
// IF/ID register, with a LOAD/RUN/HALTED sequencer for debug programming.
module if_fetch_stage #(
   parameter int               NBITS     = 32,
   parameter int               ADDR_BITS = 8,
   parameter logic [NBITS-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   input  logic                 i_enable,
   input  logic                 i_start,
   input  logic                 i_imem_wr_en,
   input  logic [ADDR_BITS-1:0] i_imem_wr_addr,
   input  logic [NBITS-1:0]     i_imem_wr_data,
   input  logic                 i_pc_write,
   input  logic                 i_ifid_write,
   input  logic                 i_flush,
   input  logic [1:0]           i_pc_src,
   input  logic [NBITS-1:0]     i_branch_addr,
   input  logic [NBITS-1:0]     i_jump_addr,
   input  logic [NBITS-1:0]     i_jalr_addr,
   output logic [NBITS-1:0]     o_pc,
   output logic [NBITS-1:0]     o_ifid_instr,
   output logic [NBITS-1:0]     o_ifid_pc4,
   output logic                 o_ifid_valid,
   output logic [1:0]           o_state,
   output logic                 o_halted
);

   typedef enum logic [1:0] {
      S_LOAD = 2'b00,
      S_RUN  = 2'b01,
      S_HALT = 2'b10
   } state_t;

   state_t           r_state;
   logic [NBITS-1:0] r_pc;
   logic [NBITS-1:0] r_instr;
   logic [NBITS-1:0] r_pc4;
   logic             r_valid;
   logic [NBITS-1:0] r_imem [2**ADDR_BITS];

   logic [NBITS-1:0] w_fetch;
   logic [NBITS-1:0] w_pc4;
   logic [NBITS-1:0] w_next_pc;
   logic             w_is_halt;

   assign w_fetch   = r_imem[r_pc[ADDR_BITS+1:2]];
   assign w_pc4     = r_pc + NBITS'(4);
   assign w_is_halt = (w_fetch == HALT_WORD);

   always_comb begin
      w_next_pc = w_pc4;
      unique case (i_pc_src)
         2'b00: w_next_pc = w_pc4;
         2'b01: w_next_pc = i_branch_addr;
         2'b10: w_next_pc = i_jump_addr;
         2'b11: w_next_pc = i_jalr_addr;
         default: w_next_pc = w_pc4;
      endcase
   end

   // Memory has no reset so a loaded program survives a pipeline reset.
   always_ff @(posedge i_clk) begin
      if (i_reset_n && i_enable && i_imem_wr_en && r_state == S_LOAD)
         r_imem[i_imem_wr_addr] <= i_imem_wr_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_LOAD;
         r_pc    <= '0;
         r_instr <= '0;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (i_enable) begin
         unique case (r_state)
            S_LOAD: begin
               if (i_start)
                  r_state <= S_RUN;
            end
            S_RUN: begin
               if (i_flush) begin
                  r_pc    <= w_next_pc;
                  r_instr <= '0;
                  r_pc4   <= '0;
                  r_valid <= 1'b0;
               end else begin
                  if (i_ifid_write) begin
                     r_instr <= w_fetch;
                     r_pc4   <= w_pc4;
                     r_valid <= 1'b1;
                     if (w_is_halt)
                        r_state <= S_HALT;
                  end
                  if (i_pc_write && !(i_ifid_write && w_is_halt))
                     r_pc <= w_next_pc;
               end
            end
            S_HALT: begin
               r_instr <= '0;
               r_pc4   <= '0;
               r_valid <= 1'b0;
               // An older branch squashing the speculative HALT resumes fetch.
               if (i_flush) begin
                  r_pc    <= w_next_pc;
                  r_state <= S_RUN;
               end
            end
            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign o_pc         = r_pc;
   assign o_ifid_instr = r_instr;
   assign o_ifid_pc4   = r_pc4;
   assign o_ifid_valid = r_valid;
   assign o_state      = r_state;
   assign o_halted     = (r_state == S_HALT);

endmodule
